// File: rtl/data_path.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_path                                                      |
// | Purpose  : Push-button-stepped serial frame receiver. A one-pulser turns  |
// |            each clkPB press into a single-cycle step. The protocol engine |
// |            waits for a start bit (0), collects a 4-bit length MSB first,  |
// |            then forwards that many payload bits from SerIn to SerOut with |
// |            valid high. The 7-segment digit shows the payload bits still   |
// |            to come.                                                       |
// | Ports    : clock   - system clock, rising edge                            |
// |            reset   - synchronous, active-high                             |
// |            clkPB   - asynchronous push-button level                       |
// |            SerIn   - serial data, sampled when a step is consumed         |
// |            display - active-low segments {g,f,e,d,c,b,a}                  |
// |            valid   - high while payload bits are being forwarded          |
// |            SerOut  - SerIn while valid, else 0                            |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module data_path (
   input  logic       clock,
   input  logic       reset,
   input  logic       clkPB,
   input  logic       SerIn,
   output logic [6:0] display,
   output logic       valid,
   output logic       SerOut
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LEN  = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       sync1_q, sync2_q, sync3_q;
   logic [2:0] len_q,   len_d;   // first three length bits; the fourth arrives with the completing step
   logic [1:0] idx_q,   idx_d;
   logic [3:0] cnt_q,   cnt_d;
   logic       valid_q, valid_d;
   logic       step;
   logic [3:0] len_full;

   // sync1/sync2 resynchronise the button; sync3 holds the previous level so
   // a held button yields exactly one step.
   assign step     = sync2_q & ~sync3_q;
   assign len_full = {len_q, SerIn};

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (step && !SerIn) begin
               len_d   = 3'd0;
               idx_d   = 2'd0;
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (step) begin
               len_d = len_full[2:0];
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  cnt_d   = len_full;
                  // A zero-length frame carries no payload.
                  state_d = (len_full != 4'd0) ? S_DATA : S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (step) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      valid_d = (state_d == S_DATA);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
         state_q <= S_IDLE;
         len_q   <= 3'd0;
         idx_q   <= 2'd0;
         cnt_q   <= 4'd0;
         valid_q <= 1'b0;
      end else begin
         sync1_q <= clkPB;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      display = 7'b1000000;
      case (cnt_q)
         4'h0: display = 7'b1000000;
         4'h1: display = 7'b1111001;
         4'h2: display = 7'b0100100;
         4'h3: display = 7'b0110000;
         4'h4: display = 7'b0011001;
         4'h5: display = 7'b0010010;
         4'h6: display = 7'b0000010;
         4'h7: display = 7'b1111000;
         4'h8: display = 7'b0000000;
         4'h9: display = 7'b0010000;
         4'hA: display = 7'b0001000;
         4'hB: display = 7'b0000011;
         4'hC: display = 7'b1000110;
         4'hD: display = 7'b0100001;
         4'hE: display = 7'b0000110;
         4'hF: display = 7'b0001110;
         default: display = 7'b1000000;
      endcase
   end

   assign valid  = valid_q;
   assign SerOut = valid_q & SerIn;

endmodule
`default_nettype wire

// File: tb/tb_data_path.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_data_path                                                   |
// | Purpose  : Self-checking bench for data_path. Button presses are driven  |
// |            as directed and random frames; a frame-level reference model   |
// |            predicts valid, display and SerOut after every press.         |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_data_path;

   logic       clock = 1'b0;
   logic       reset;
   logic       clkPB;
   logic       SerIn;
   logic [6:0] display;
   logic       valid;
   logic       SerOut;

   int errors = 0;
   int checks = 0;

   // Reference model: frame-level view of the protocol.
   bit m_collect;   // collecting length bits
   bit m_payload;   // forwarding payload
   int m_nbits;
   int m_len;
   int m_remain;

   logic [6:0] seg [16];

   always #5 clock = ~clock;

   data_path dut (
      .clock   (clock),
      .reset   (reset),
      .clkPB   (clkPB),
      .SerIn   (SerIn),
      .display (display),
      .valid   (valid),
      .SerOut  (SerOut)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_collect = 0;
      m_payload = 0;
      m_nbits   = 0;
      m_len     = 0;
      m_remain  = 0;
   endfunction

   function automatic void model_step(input bit b);
      if (m_payload) begin
         m_remain = m_remain - 1;
         if (m_remain == 0) m_payload = 0;
      end else if (m_collect) begin
         m_len   = m_len * 2 + int'(b);
         m_nbits = m_nbits + 1;
         if (m_nbits == 4) begin
            m_collect = 0;
            m_remain  = m_len;
            m_payload = (m_len != 0);
         end
      end else if (!b) begin
         m_collect = 1;
         m_nbits   = 0;
         m_len     = 0;
      end
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, "_valid"},   {31'd0, valid},   {31'd0, m_payload});
      check({tag, "_display"}, {25'd0, display}, {25'd0, seg[m_remain]});
      check({tag, "_serout"},  {31'd0, SerOut},  {31'd0, (m_payload & SerIn)});
   endtask

   // One button press: outputs keep their old value two edges after the
   // press is captured, hold the new value afterwards, and a held button
   // never produces a second step.
   task automatic press(input bit b, input int hold);
      SerIn = b;
      clkPB = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1;
      check_outputs("pre");
      model_step(b);
      @(posedge clock);
      @(posedge clock);
      #1;
      check_outputs("post");
      repeat (hold - 4) @(posedge clock);
      #1;
      clkPB = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      SerIn = 1'($urandom);
      #1;
      check_outputs("rel");
   endtask

   task automatic frame(input int n, input bit rand_bits);
      bit b;
      press(1'b0, 4);
      for (int i = 3; i >= 0; i--) press(1'(n >> i), 4);
      for (int i = 0; i < n; i++) begin
         b = rand_bits ? 1'($urandom) : 1'b1;
         press(b, 4 + int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      seg[0]  = 7'b1000000; seg[1]  = 7'b1111001; seg[2]  = 7'b0100100; seg[3]  = 7'b0110000;
      seg[4]  = 7'b0011001; seg[5]  = 7'b0010010; seg[6]  = 7'b0000010; seg[7]  = 7'b1111000;
      seg[8]  = 7'b0000000; seg[9]  = 7'b0010000; seg[10] = 7'b0001000; seg[11] = 7'b0000011;
      seg[12] = 7'b1000110; seg[13] = 7'b0100001; seg[14] = 7'b0000110; seg[15] = 7'b0001110;

      // Reset
      reset = 1'b1;
      clkPB = 1'b0;
      SerIn = 1'b1;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_outputs("reset");
      reset = 1'b0;
      repeat (3) press(1'b1, 4);

      // Full frame: length 1101, then 13 payload bits
      press(1'b0, 4);
      press(1'b1, 4);
      press(1'b1, 4);
      press(1'b0, 4);
      press(1'b1, 4);
      check("frame_len_d", {25'd0, display}, {25'd0, 7'b0100001});
      check("frame_valid_up", {31'd0, valid}, 32'd1);
      press(1'b0, 4);
      for (int i = 0; i < 12; i++) press(1'b1, 4);
      check("frame_end_display", {25'd0, display}, {25'd0, 7'b1000000});
      check("frame_end_valid", {31'd0, valid}, 32'd0);

      // Zero length
      frame(0, 1'b0);
      check("zero_valid", {31'd0, valid}, 32'd0);

      // Long press: one 50-cycle hold consumes exactly one payload bit
      press(1'b0, 4);
      press(1'b0, 4);
      press(1'b0, 4);
      press(1'b1, 4);
      press(1'b1, 4);
      press(1'b1, 50);
      check("long_display", {25'd0, display}, {25'd0, 7'b0100100});
      press(1'b0, 4);
      press(1'b1, 4);

      // Reset mid-frame with count 7
      press(1'b0, 4);
      press(1'b1, 4);
      press(1'b0, 4);
      press(1'b1, 4);
      press(1'b1, 4);
      repeat (4) press(1'b1, 4);
      check("mid_count7", {25'd0, display}, {25'd0, 7'b1111000});
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      check_outputs("midreset");
      frame(2, 1'b1);

      // Maximum length
      frame(15, 1'b1);

      // Random frames separated by ignored idle presses
      for (int f = 0; f < 6; f++) begin
         repeat ($urandom_range(0, 2)) press(1'b1, 4);
         frame(int'($urandom_range(0, 15)), 1'b1);
      end

      // Fully random press sequence
      for (int i = 0; i < 40; i++) press(1'($urandom), 4 + int'($urandom_range(0, 3)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
